// File: rtl/apb_master.sv
// Command-to-APB bridge: runs one APB transfer (SETUP, ACCESS) per accepted command
// and returns read data plus error/timeout status on a valid/ready response port.
module apb_master #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] TLAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          accept;
  logic          expire;

  // Expiry fires on the ACCESS cycle whose wait would bring the count up to TIMEOUT,
  // so ACCESS lasts exactly TIMEOUT cycles; a PREADY in that cycle still completes.
  always_comb begin
    state_next = state;
    accept     = cmd_valid && cmd_ready;
    expire     = TIMEOUT_EN && !PREADY && (count == TLAST);
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (PREADY || expire) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == IDLE);
    end
  end

  // Bus fields are loaded only on acceptance and otherwise held, so they stay
  // valid after the transfer ends.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (state == IDLE && accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
    end
  end

  // Wait-state counter saturates at TIMEOUT instead of wrapping.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      count <= '0;
    end else if (state == SETUP) begin
      count <= '0;
    end else if (state == ACCESS && !PREADY && count != TLIMIT) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (state == ACCESS) begin
      if (PREADY) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (expire) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: plays the APB slave, queues expected responses on command
// issue and compares them when the response handshake occurs.
module tb_apb_master;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          PCLK;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  rsp_t sbQueue[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  apb_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One complete transfer: waits = PREADY-low ACCESS cycles before PREADY (>= TMO never
  // asserts it), stall = cycles rsp_ready stays low with a second command held.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                               input int waits, input logic [DW-1:0] rd, input logic err, input int stall);
    int   n;
    int   acc;
    logic tmo;
    rsp_t exp;
    rsp_t got;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    tmo       = (waits >= TMO);
    exp.rdata = (tmo || wr) ? '0 : rd;
    exp.err   = tmo ? 1'b1 : err;
    exp.tmo   = tmo;
    sbQueue.push_back(exp);
    tick();
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    PREADY    = 1'b1;
    PSLVERR   = 1'b1;
    PRDATA    = DW'($urandom);
    checkOutput("setup_psel", PSEL, 1);
    checkOutput("setup_penable", PENABLE, 0);
    checkOutput("setup_cmd_ready", cmd_ready, 0);
    tick();
    acc = 0;
    while (rsp_valid !== 1'b1 && acc < 40) begin
      acc++;
      checkOutput("access_psel", PSEL, 1);
      checkOutput("access_penable", PENABLE, 1);
      checkOutput("access_paddr", PADDR, addr);
      checkOutput("access_pwrite", PWRITE, wr);
      if (wr) checkOutput("access_pwdata", PWDATA, wd);
      if (acc > waits) begin
        PREADY  = 1'b1;
        PRDATA  = rd;
        PSLVERR = err;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = DW'($urandom);
        PSLVERR = 1'($urandom);
      end
      tick();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    checkOutput("access_cycles", acc, tmo ? TMO : waits + 1);
    checkOutput("rsp_valid", rsp_valid, 1);
    checkOutput("rsp_psel", PSEL, 0);
    checkOutput("rsp_penable", PENABLE, 0);
    checkOutput("rsp_paddr_held", PADDR, addr);
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      tick();
      checkOutput("stall_rsp_valid", rsp_valid, 1);
      checkOutput("stall_cmd_ready", cmd_ready, 0);
      checkOutput("stall_psel", PSEL, 0);
      checkOutput("stall_rdata", rsp_rdata, exp.rdata);
      checkOutput("stall_err", rsp_err, exp.err);
    end
    cmd_valid = 1'b0;
    if (sbQueue.size() == 0) begin
      checkOutput("sb_underflow", 1, 0);
    end else begin
      got = sbQueue.pop_front();
      checkOutput("rsp_rdata", rsp_rdata, got.rdata);
      checkOutput("rsp_err", rsp_err, got.err);
      checkOutput("rsp_timeout", rsp_timeout, got.tmo);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("post_rsp_valid", rsp_valid, 0);
    checkOutput("post_cmd_ready", cmd_ready, 1);
    checkOutput("post_psel", PSEL, 0);
  endtask

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    tick();
    tick();
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    checkOutput("reset_psel", PSEL, 0);
    checkOutput("reset_penable", PENABLE, 0);
    checkOutput("reset_pwrite", PWRITE, 0);
    checkOutput("reset_paddr", PADDR, 0);
    checkOutput("reset_pwdata", PWDATA, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);
    checkOutput("reset_rsp_timeout", rsp_timeout, 0);
    PRESET = 1'b0;
    tick();
    checkOutput("reset_release_cmd_ready", cmd_ready, 1);

    applyStimulus(1'b1, 4'h3, 8'hA5, 0,   8'h00, 1'b0, 0);
    applyStimulus(1'b0, 4'h7, 8'h00, 3,   8'h5C, 1'b0, 0);
    applyStimulus(1'b0, 4'h2, 8'h00, 1,   8'h3C, 1'b1, 0);
    applyStimulus(1'b0, 4'h5, 8'h00, TMO, 8'hEE, 1'b0, 0);
    applyStimulus(1'b0, 4'hB, 8'h00, TMO - 1, 8'h81, 1'b0, 0);
    applyStimulus(1'b1, 4'hC, 8'h3E, 2,   8'h77, 1'b1, 5);

    // Abandon a read mid-ACCESS with a reset pulse.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'h9;
    tick();
    cmd_valid = 1'b0;
    tick();
    checkOutput("prerst_penable", PENABLE, 1);
    PRESET = 1'b1;
    tick();
    checkOutput("midrst_psel", PSEL, 0);
    checkOutput("midrst_penable", PENABLE, 0);
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_cmd_ready", cmd_ready, 0);
    checkOutput("midrst_paddr", PADDR, 0);
    PRESET = 1'b0;
    tick();
    checkOutput("midrst_release_cmd_ready", cmd_ready, 1);
    checkOutput("midrst_no_rsp", rsp_valid, 0);

    applyStimulus(1'b1, 4'h1, 8'h96, 0, 8'h00, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 4)),
                    DW'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    checkOutput("sb_empty", sbQueue.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Command-to-APB bridge: accepts single read/write commands on a valid/ready port and executes each as one APB transfer (SETUP then ACCESS, waiting on PREADY). It drives the master side of the APB bus (PSEL, PENABLE, PWRITE, PADDR, PWDATA) that feeds the APB address decoder and APB slaves of the APB-SPI subsystem. Each transfer ends with a response carrying read data and error status. It replaces the testbench as the APB bus driver.

## Interface
- AWIDTH, 4, APB address width
- DWIDTH, 8, APB data width
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY; 0 disables timeout
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  reset; synchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AWIDTH  transfer address
- cmd_wdata  in  DWIDTH  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DWIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR sampled at completion, or 1 on timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  AWIDTH  APB address
- PWDATA  out  DWIDTH  APB write data
- PRDATA  in  DWIDTH  APB read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave/decoder error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid: register cmd_write/addr/wdata into PWRITE/PADDR/PWDATA; go to SETUP.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle; go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. On PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR, rsp_timeout=0; go to RESP.
- Timeout: counter cleared on entering ACCESS, incremented each ACCESS cycle with PREADY=0. When count reaches TIMEOUT (TIMEOUT>0): rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP. PREADY in the same cycle as expiry wins (normal completion).
- RESP: PSEL=0, PENABLE=0, rsp_valid=1. Response fields stable until handshake; on rsp_ready go to IDLE.
- cmd_ready=0 in SETUP, ACCESS, RESP. One outstanding transfer max.
- PADDR, PWRITE, PWDATA hold their values from SETUP through end of ACCESS and keep them after (no return to 0).
- Counter width $clog2(TIMEOUT+1), minimum 1; never wraps (stops at TIMEOUT).

## Timing
- All outputs registered or decoded from state register only; no combinational path from inputs to outputs.
- While PRESET=1 and on the first edge after deassertion: state=IDLE, cmd_ready=0 while PRESET=1 then 1; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0.
- Command accepted at edge 0 -> SETUP visible cycle 1 -> ACCESS cycle 2; PREADY=1 in cycle 2 -> rsp_valid cycle 3. Each PREADY wait state adds 1 cycle.
- rsp_ready held high: IDLE in cycle 4, next command accepted at edge ending cycle 4 at earliest; minimum 4 cycles per transfer.
- PRESET mid-transfer: next edge forces IDLE state, PSEL/PENABLE=0; transfer abandoned, no response issued.
- PREADY/PRDATA/PSLVERR ignored outside ACCESS.

## Test plan
- Write 0xA5 to addr 0x3, PREADY=1 immediately -> PSEL rises cycle 1, PENABLE cycle 2 with PADDR=0x3, PWDATA=0xA5, PWRITE=1; rsp_valid cycle 3 with rsp_rdata=0, rsp_err=0.
- Read addr 0x7, PREADY low 3 cycles, then high with PRDATA=0x5C -> PENABLE high 4 cycles, PADDR stable; rsp_rdata=0x5C, rsp_err=0, rsp_timeout=0.
- Read with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0, rsp_rdata=PRDATA.
- PREADY never asserted, TIMEOUT=16 -> ACCESS lasts exactly 16 cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSEL drops with rsp_valid.
- rsp_ready low 5 cycles with cmd_valid held -> rsp_valid and fields stable, cmd_ready=0, no new SETUP until after handshake.
- PRESET pulsed during ACCESS -> next edge PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1 after deassertion; following command runs normally.
